// File: rtl/cmp_rgb_pkg.sv
// cmp_rgb_pkg: shared types and constants for the serial RGB comparator
package cmp_rgb_pkg;
  typedef enum logic {IDLE, CMP} state_t;
  typedef struct packed {
    logic ge;
    logic le;
    logic ne;
  } cmp_flags_t;
  localparam cmp_flags_t FLAGS_EQ = '{ge: 1'b1, le: 1'b1, ne: 1'b0};
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM counter; all-ones brightness means fully on
module pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                on
);
  logic [PWM_BITS-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt + PWM_BITS'(1);
  assign on = (&brightness) | (cnt < brightness);
endmodule

// File: rtl/cmp_rgb_serial.sv
// cmp_rgb_serial: MSB-first bit-serial magnitude compare with early exit,
// driving PWM-dimmed RGB LEDs from the registered ge/le/ne flags.
module cmp_rgb_serial
  import cmp_rgb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                signed_mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                busy,
  output logic                done,
  output logic                a_ge_b,
  output logic                a_le_b,
  output logic                a_ne_b,
  output logic                red,
  output logic                green,
  output logic                blue
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IMAX = IW'(WIDTH - 1);
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r, a_n, b_n;
  logic             sm_r, sm_n;
  logic [IW-1:0]    idx, idx_n;
  cmp_flags_t       flags, flags_n;
  logic             busy_n, done_n, valid, valid_n;
  logic             on, diff, a_gt, finish;
  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .brightness(brightness),
    .on        (on)
  );
  // On the sign bit of a signed compare a set A bit marks the smaller operand
  assign diff   = a_r[idx] ^ b_r[idx];
  assign a_gt   = a_r[idx] ^ (sm_r & (idx == IMAX));
  assign finish = (state == CMP) & (diff | (idx == '0));
  always_comb begin
    state_n = state;
    a_n     = a_r;
    b_n     = b_r;
    sm_n    = sm_r;
    idx_n   = idx;
    flags_n = flags;
    busy_n  = busy;
    valid_n = valid;
    done_n  = finish;
    if (state == IDLE && start) begin
      a_n     = a;
      b_n     = b;
      sm_n    = signed_mode;
      idx_n   = IMAX;
      busy_n  = 1'b1;
      state_n = CMP;
    end else if (finish) begin
      flags_n = diff ? '{ge: a_gt, le: ~a_gt, ne: 1'b1} : FLAGS_EQ;
      busy_n  = 1'b0;
      valid_n = 1'b1;
      state_n = IDLE;
    end else if (state == CMP) begin
      idx_n = idx - IW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      sm_r  <= 1'b0;
      idx   <= '0;
      flags <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      state <= state_n;
      a_r   <= a_n;
      b_r   <= b_n;
      sm_r  <= sm_n;
      idx   <= idx_n;
      flags <= flags_n;
      busy  <= busy_n;
      done  <= done_n;
      valid <= valid_n;
      red   <= flags.ge & on & valid;
      green <= flags.le & on & valid;
      blue  <= flags.ne & on & valid;
    end
  end
  assign a_ge_b = flags.ge;
  assign a_le_b = flags.le;
  assign a_ne_b = flags.ne;
endmodule

// File: tb/tb_cmp_rgb_serial.sv
// tb_cmp_rgb_serial: scoreboard bench for the serial RGB comparator
module tb_cmp_rgb_serial;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       signed_mode = 1'b0;
  logic [3:0] brightness = 4'hF;
  logic       busy, done, a_ge_b, a_le_b, a_ne_b, red, green, blue;
  int         checks = 0;
  int         fails = 0;

  typedef struct {
    logic ge;
    logic le;
    logic ne;
    int   lat;
  } exp_t;
  exp_t sb[$];

  cmp_rgb_serial #(.WIDTH(8), .PWM_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .brightness (brightness),
    .busy       (busy),
    .done       (done),
    .a_ge_b     (a_ge_b),
    .a_le_b     (a_le_b),
    .a_ne_b     (a_ne_b),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] va, input logic [7:0] vb, input logic vsm);
    exp_t e;
    e.lat = 8;
    for (int i = 0; i < 8; i++) if (va[i] != vb[i]) e.lat = 8 - i;
    e.ge = vsm ? ($signed(va) >= $signed(vb)) : (va >= vb);
    e.le = vsm ? ($signed(va) <= $signed(vb)) : (va <= vb);
    e.ne = (va != vb);
    return e;
  endfunction

  task automatic run_compare(input logic [7:0] va, input logic [7:0] vb, input logic vsm,
                             input int poke, input string name);
    exp_t e;
    int   lat;
    sb.push_back(model(va, vb, vsm));
    @(negedge clk);
    a = va; b = vb; signed_mode = vsm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_after_start: busy=%b done=%b, expected busy=1 done=0", name, busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == poke) begin
        start = 1'b1; a = ~va; b = vb ^ 8'h0F; signed_mode = ~vsm;
      end else start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, lat);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (lat != e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, e.lat);
    end
    checks++;
    if ({a_ge_b, a_le_b, a_ne_b, busy} !== {e.ge, e.le, e.ne, 1'b0}) begin
      fails++;
      $display("FAIL %s flags: ge/le/ne/busy=%b%b%b%b, expected %b%b%b0", name,
               a_ge_b, a_le_b, a_ne_b, busy, e.ge, e.le, e.ne);
    end
    @(negedge clk);
    checks++;
    if ({done, red, green, blue} !== {1'b0, e.ge, e.le, e.ne}) begin
      fails++;
      $display("FAIL %s leds: done/r/g/b=%b%b%b%b, expected 0%b%b%b", name,
               done, red, green, blue, e.ge, e.le, e.ne);
    end
  endtask

  task automatic test_reset();
    int lit;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, a_ge_b, a_le_b, a_ne_b, red, green, blue} !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: outputs=%b, expected 00000000",
               {busy, done, a_ge_b, a_le_b, a_ne_b, red, green, blue});
    end
    rst_n = 1'b1;
    lit = 0;
    repeat (20) begin
      @(negedge clk);
      if (red | green | blue | busy | done) lit++;
    end
    checks++;
    if (lit != 0) begin
      fails++;
      $display("FAIL leds_before_first_compare: %0d active cycles, expected 0", lit);
    end
  endtask

  task automatic test_basic();
    run_compare(8'h80, 8'h7F, 1'b0, 0, "unsigned_msb");
    run_compare(8'h5A, 8'h5A, 1'b0, 0, "equal");
  endtask

  task automatic test_signed();
    run_compare(8'h80, 8'h01, 1'b1, 0, "signed_neg");
    run_compare(8'h80, 8'h01, 1'b0, 0, "unsigned_big");
    run_compare(8'hFF, 8'hFE, 1'b1, 0, "signed_lsb");
    run_compare(8'h7F, 8'h80, 1'b1, 0, "signed_pos_neg");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_compare(8'($urandom), 8'($urandom), 1'($urandom), 0, "random");
  endtask

  task automatic test_ignore_start();
    int extra;
    run_compare(8'h5A, 8'h5A, 1'b0, 3, "start_mid_compare");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL start_mid_compare_extra_done: %0d extra dones, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    sb.push_back(model(8'h80, 8'h7F, 1'b0));
    sb.push_back(model(8'h01, 8'h02, 1'b0));
    @(negedge clk);
    a = 8'h80; b = 8'h7F; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({done, a_ge_b, a_le_b, a_ne_b} !== {1'b1, e.ge, e.le, e.ne}) begin
      fails++;
      $display("FAIL b2b_first: done/ge/le/ne=%b%b%b%b, expected 1%b%b%b",
               done, a_ge_b, a_le_b, a_ne_b, e.ge, e.le, e.ne);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_second_accept: busy/done=%b%b, expected 10", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || lat != e.lat || {a_ge_b, a_le_b, a_ne_b} !== {e.ge, e.le, e.ne}) begin
      fails++;
      $display("FAIL b2b_second: done=%b lat=%0d flags=%b%b%b, expected done=1 lat=%0d flags=%b%b%b",
               done, lat, a_ge_b, a_le_b, a_ne_b, e.lat, e.ge, e.le, e.ne);
    end
  endtask

  task automatic test_pwm();
    int      nr, ng, nb, er;
    logic [3:0] lv [3] = '{4'd4, 4'd0, 4'd15};
    run_compare(8'h80, 8'h7F, 1'b0, 0, "pwm_setup");
    foreach (lv[i]) begin
      brightness = lv[i];
      repeat (2) @(negedge clk);
      nr = 0; ng = 0; nb = 0;
      repeat (32) begin
        @(negedge clk);
        nr += int'(red); ng += int'(green); nb += int'(blue);
      end
      er = (lv[i] == 4'd15) ? 32 : 2 * int'(lv[i]);
      checks++;
      if (nr != er || nb != er || ng != 0) begin
        fails++;
        $display("FAIL pwm_b%0d: red=%0d green=%0d blue=%0d of 32, expected red=%0d green=0 blue=%0d",
                 lv[i], nr, ng, nb, er, er);
      end
    end
    brightness = 4'hF;
  endtask

  task automatic test_reset_mid();
    int nd;
    run_compare(8'h80, 8'h7F, 1'b0, 0, "pre_reset");
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, a_ge_b, a_le_b, a_ne_b, red, green, blue} !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_compare: outputs=%b, expected 00000000",
               {busy, done, a_ge_b, a_le_b, a_ne_b, red, green, blue});
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (16) begin
      @(negedge clk);
      if (done | busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      fails++;
      $display("FAIL reset_no_done: %0d cycles with done/busy, expected 0", nd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_pwm();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cmp_rgb_serial.md
Name: cmp_rgb_serial

Overview:
- Parametrised, sequential successor to the 2-bit RGB magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, one bit per clock, with early exit on the first differing bit. Supports unsigned or two's-complement operands.
- Registers ge/le/ne result flags and drives the board RGB LED from them: red = a>=b, green = a<=b, blue = a!=b.
- LED brightness is set by a free-running PWM.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- PWM_BITS, 4, PWM counter width; period is 2^PWM_BITS cycles.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- signed_mode  in  1  1 = two's-complement compare; captured with the operands.
- brightness  in  PWM_BITS  LED duty level; sampled every cycle.
- busy  out  1  compare in progress.
- done  out  1  one-cycle pulse when the flags update.
- a_ge_b  out  1  registered result flag.
- a_le_b  out  1  registered result flag.
- a_ne_b  out  1  registered result flag.
- red  out  1  PWM-gated a_ge_b.
- green  out  1  PWM-gated a_le_b.
- blue  out  1  PWM-gated a_ne_b.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - busy, done, a_ge_b, a_le_b, a_ne_b, red, green, blue, result_valid = 0.
  - PWM counter = 0.
- States: IDLE, CMP.
- IDLE:
  - start=1 at edge E0: latch a, b, signed_mode into internal registers; idx = WIDTH-1; busy=1; go to CMP.
  - start=0: remain in IDLE.
- CMP, each edge examines bit idx of the latched operands:
  - Bits differ:
    - Unsigned, or idx != WIDTH-1: A bit = 1 means a>b.
    - Signed and idx == WIDTH-1 (sign bit): A bit = 1 means a<b.
    - Set flags accordingly (ge/le exactly one set, ne=1). Pulse done=1, busy=0, result_valid=1, go to IDLE.
  - Bits equal and idx == 0: ge=1, le=1, ne=0; pulse done=1, busy=0, result_valid=1, go to IDLE.
  - Bits equal and idx > 0: idx decrements.
- Latency:
  - First differing bit at position k: done is registered at edge E0+(WIDTH-k).
  - Equal operands: done at edge E0+WIDTH, which is the worst case.
  - Minimum (MSB differs): E0+1.
- Done and flags:
  - done is high for exactly one cycle, then returns to 0.
  - Flags hold their value until the next done.
- start while busy: ignored; no queueing. Input changes during CMP do not affect the compare in flight.
- start in the cycle done is high: state is already IDLE, so it is accepted. Back-to-back compares are allowed with no gap.
- PWM:
  - Counter free-runs 0..2^PWM_BITS-1 and wraps to 0.
  - on = (cnt < brightness), except brightness = all-ones gives on = 1 constantly.
  - brightness = 0 gives always off.
- LED outputs:
  - Registered: red <= a_ge_b & on & result_valid; green and blue likewise. One cycle of delay relative to the flags and the PWM counter.
  - LEDs stay 0 until the first compare completes after reset.
- Reset mid-compare:
  - All outputs drop immediately (asynchronously).
  - No done is produced for the aborted compare after rst_n releases.

Decomposition:
- Package cmp_rgb_pkg:
  - state_t enum {IDLE, CMP}.
  - cmp_flags_t packed struct {ge, le, ne}.
  - Constant FLAGS_EQ = {1,1,0}.
- Sub-module pwm_gen (param PWM_BITS):
  - Inputs: clk, rst_n, brightness.
  - Output: on.
  - Contains the counter and compare.
- The comparator FSM and LED output registers stay in cmp_rgb_serial.

Test Plan (WIDTH=8, PWM_BITS=4, brightness=15 unless stated):
1. Unsigned, a=0x80, b=0x7F, start at E0 -> done at E0+1; ge=1, le=0, ne=1; busy high one cycle; red=1, green=0, blue=1 at E0+2.
2. a=b=0x5A -> done at E0+8; ge=1, le=1, ne=0; blue=0.
3. a=0x80, b=0x01: signed_mode=1 -> ge=0, le=1, ne=1; repeat with signed_mode=0 -> ge=1, le=0. Also signed a=0xFF, b=0xFE (bits differ at k=0) -> ge=1, done at E0+8.
4. start pulsed mid-compare -> no effect, single done. start held high across the done cycle -> second compare is accepted, with busy re-asserted on the next edge.
5. Flags ge=1: brightness=4 -> red high exactly 4 of every 16 cycles; brightness=0 -> red never high; brightness=15 -> red constantly high. Before the first compare, all LEDs = 0.
6. rst_n=0 at E0+3 of an equal compare -> busy, flags and LEDs = 0 immediately; after release, no done appears within 16 cycles.
